// File: rtl/nand_clk_rst_seq.sv
// Purpose : Power-up sequencer for the NAND PHY clocking. It resets the MMCM, waits for lock, resets the
//           IDELAYCTRL, waits for ready, then releases the PHY reset followed by the user reset.
// Latency : Outputs are registered and switch on the same edge as the state they reflect.
//           Lock and ready decisions see the raw inputs two cycles late, because of the synchronizers.
// Backpressure: None. The sequencer has no handshake. restart and reset are honoured on every cycle.
//
// Ports:
//   clk_in         free-running 50 MHz board clock (rising edge only)
//   reset          synchronous active-high block reset (highest priority)
//   mmcm_locked    MMCM lock, asynchronous, synchronized internally
//   idelayctrl_rdy IDELAYCTRL ready, asynchronous, synchronized internally
//   restart        one-cycle request to rerun the whole sequence
//   mmcm_reset     active-high MMCM reset
//   idelayctrl_rst active-high IDELAYCTRL reset
//   phy_resetn     active-low reset for the NAND PHY clock domains
//   usr_resetn     active-low reset for the 50 MHz user domain
//   seq_done       high while in RUN
//   seq_error      high while in ERROR
//   retry_cnt      failed attempts since the last reset/restart (saturating)
//   state_o        state code; ERROR reads back as 0 with seq_error=1
module nand_clk_rst_seq #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int STAGE_GAP    = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       mmcm_locked,
    input  logic       idelayctrl_rdy,
    input  logic       restart,
    output logic       mmcm_reset,
    output logic       idelayctrl_rst,
    output logic       phy_resetn,
    output logic       usr_resetn,
    output logic       seq_done,
    output logic       seq_error,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_MMCM_RST  = 4'd1;
    localparam logic [3:0] ST_WAIT_LOCK = 4'd2;
    localparam logic [3:0] ST_IDLY_RST  = 4'd3;
    localparam logic [3:0] ST_WAIT_RDY  = 4'd4;
    localparam logic [3:0] ST_REL_PHY   = 4'd5;
    localparam logic [3:0] ST_REL_USR   = 4'd6;
    localparam logic [3:0] ST_RUN       = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

    // The dwell counter starts at 0 on entry, so the last cycle of an N-cycle window is N-1.
    localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD - 1);
    localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST    = 16'(STAGE_GAP - 1);
    localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

    logic        lk_m, lk_s;
    logic        rd_m, rd_s;
    logic [3:0]  state, state_nxt;
    logic [15:0] dwell, dwell_nxt;
    logic [2:0]  retry_nxt;
    logic        fail;

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        fail      = 1'b0;

        case (state)
            ST_IDLE:      state_nxt = ST_MMCM_RST;
            ST_MMCM_RST:  if (dwell == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                // A lock seen on the final cycle of the window still counts as success.
                if (lk_s)                   state_nxt = ST_IDLY_RST;
                else if (dwell == TMO_LAST) fail      = 1'b1;
            end
            ST_IDLY_RST: begin
                if (!lk_s)                   fail      = 1'b1;
                else if (dwell == HOLD_LAST) state_nxt = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (!lk_s)                  fail      = 1'b1;
                else if (rd_s)              state_nxt = ST_REL_PHY;
                else if (dwell == TMO_LAST) fail      = 1'b1;
            end
            ST_REL_PHY: begin
                if (!lk_s)                  fail      = 1'b1;
                else if (dwell == GAP_LAST) state_nxt = ST_REL_USR;
            end
            ST_REL_USR: begin
                if (!lk_s)                  fail      = 1'b1;
                else if (dwell == GAP_LAST) state_nxt = ST_RUN;
            end
            ST_RUN:   if (!lk_s) fail = 1'b1;
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_IDLE;
        endcase

        if (fail) begin
            retry_nxt = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
            state_nxt = (retry_nxt < RETRY_LIMIT) ? ST_MMCM_RST : ST_ERROR;
        end

        // restart overrides any failure decided in the same cycle.
        if (restart) begin
            retry_nxt = 3'd0;
            state_nxt = ST_IDLE;
        end

        if (state_nxt != state)     dwell_nxt = 16'd0;
        else if (dwell == 16'hFFFF) dwell_nxt = dwell;
        else                        dwell_nxt = dwell + 16'd1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            lk_m           <= 1'b0;
            lk_s           <= 1'b0;
            rd_m           <= 1'b0;
            rd_s           <= 1'b0;
            state          <= ST_IDLE;
            dwell          <= 16'd0;
            retry_cnt      <= 3'd0;
            mmcm_reset     <= 1'b1;
            idelayctrl_rst <= 1'b1;
            phy_resetn     <= 1'b0;
            usr_resetn     <= 1'b0;
            seq_done       <= 1'b0;
            seq_error      <= 1'b0;
            state_o        <= 3'd0;
        end else begin
            lk_m           <= mmcm_locked;
            lk_s           <= lk_m;
            rd_m           <= idelayctrl_rdy;
            rd_s           <= rd_m;
            state          <= state_nxt;
            dwell          <= dwell_nxt;
            retry_cnt      <= retry_nxt;
            // The outputs are decoded from the next state, so they change on the same edge as the state register.
            mmcm_reset     <= (state_nxt == ST_MMCM_RST) || (state_nxt == ST_ERROR);
            idelayctrl_rst <= (state_nxt == ST_IDLY_RST) || (state_nxt == ST_ERROR);
            phy_resetn     <= (state_nxt == ST_REL_PHY) || (state_nxt == ST_REL_USR) ||
                              (state_nxt == ST_RUN);
            usr_resetn     <= (state_nxt == ST_REL_USR) || (state_nxt == ST_RUN);
            seq_done       <= (state_nxt == ST_RUN);
            seq_error      <= (state_nxt == ST_ERROR);
            state_o        <= (state_nxt == ST_ERROR) ? 3'd0 : state_nxt[2:0];
        end
    end

endmodule

// File: tb/tb_nand_clk_rst_seq.sv
// Purpose : Bench for nand_clk_rst_seq. It compares the outputs on every cycle with a reference model,
//           and adds directed checks for the bring-up scenarios.
// Latency : Outputs are sampled 1 time unit after each rising edge. Inputs change only at that point.
// Backpressure: Not applicable.
module tb_nand_clk_rst_seq;

    localparam int RST_HOLD     = 4;
    localparam int LOCK_TIMEOUT = 32;
    localparam int STAGE_GAP    = 2;
    localparam int MAX_RETRY    = 2;

    // Model phases use the documented state_o codes; ERROR gets its own value here.
    localparam int M_IDLE = 0, M_MMCM = 1, M_WLOCK = 2, M_IDLY = 3, M_WRDY = 4;
    localparam int M_RELPHY = 5, M_RELUSR = 6, M_RUN = 7, M_ERROR = 8;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1, mmcm_locked = 1'b0, idelayctrl_rdy = 1'b0, restart = 1'b0;
    logic       mmcm_reset, idelayctrl_rst, phy_resetn, usr_resetn, seq_done, seq_error;
    logic [2:0] retry_cnt, state_o;

    int vectors = 0, miscompares = 0, cyc_no = 0;

    // Reference model state.
    int m_state = M_IDLE, m_elapsed = 1, m_retry = 0;
    bit m_after_reset = 1'b0;
    bit lk_hist[$];
    bit rd_hist[$];

    // Counters observed on the DUT outputs, used by the directed checks.
    int   n_mmcm_hi, n_idly_hi, n_wait_lock;
    int   phy_rise_cyc, usr_rise_cyc, phy_fall_cyc, usr_fall_cyc;
    logic prev_phy = 1'b0, prev_usr = 1'b0;

    nand_clk_rst_seq #(
        .RST_HOLD(RST_HOLD), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STAGE_GAP(STAGE_GAP), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_in(clk_in), .reset(reset), .mmcm_locked(mmcm_locked),
        .idelayctrl_rdy(idelayctrl_rdy), .restart(restart),
        .mmcm_reset(mmcm_reset), .idelayctrl_rst(idelayctrl_rst),
        .phy_resetn(phy_resetn), .usr_resetn(usr_resetn),
        .seq_done(seq_done), .seq_error(seq_error),
        .retry_cnt(retry_cnt), .state_o(state_o)
    );

    always #10 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] enc(input int s);
        if (s == M_ERROR) return 4'b1000;
        return {1'b0, 3'(s)};
    endfunction

    // Applies the sequencing rules at one rising edge, using the inputs the DUT samples at that edge.
    // A decision at an edge sees the raw input from two edges earlier.
    task automatic model_edge();
        bit lk, rd, fail;
        int nxt;
        if (reset) begin
            m_state = M_IDLE; m_elapsed = 1; m_retry = 0; m_after_reset = 1'b1;
            lk_hist = '{1'b0, 1'b0};
            rd_hist = '{1'b0, 1'b0};
            return;
        end
        m_after_reset = 1'b0;
        lk = lk_hist[lk_hist.size() - 2];
        rd = rd_hist[rd_hist.size() - 2];
        lk_hist.push_back(mmcm_locked);
        rd_hist.push_back(idelayctrl_rdy);
        if (lk_hist.size() > 4) void'(lk_hist.pop_front());
        if (rd_hist.size() > 4) void'(rd_hist.pop_front());

        nxt  = m_state;
        fail = 1'b0;
        if (restart) begin
            nxt = M_IDLE;
            m_retry = 0;
        end else begin
            if (m_state inside {M_IDLY, M_WRDY, M_RELPHY, M_RELUSR, M_RUN} && !lk) fail = 1'b1;
            else case (m_state)
                M_IDLE:   nxt = M_MMCM;
                M_MMCM:   if (m_elapsed == RST_HOLD) nxt = M_WLOCK;
                M_WLOCK:  if (lk) nxt = M_IDLY; else if (m_elapsed == LOCK_TIMEOUT) fail = 1'b1;
                M_IDLY:   if (m_elapsed == RST_HOLD) nxt = M_WRDY;
                M_WRDY:   if (rd) nxt = M_RELPHY; else if (m_elapsed == LOCK_TIMEOUT) fail = 1'b1;
                M_RELPHY: if (m_elapsed == STAGE_GAP) nxt = M_RELUSR;
                M_RELUSR: if (m_elapsed == STAGE_GAP) nxt = M_RUN;
                default:  ;
            endcase
            if (fail) begin
                m_retry = (m_retry < 7) ? m_retry + 1 : 7;
                nxt = (m_retry < MAX_RETRY) ? M_MMCM : M_ERROR;
            end
        end
        m_elapsed = (nxt == m_state) ? m_elapsed + 1 : 1;
        m_state   = nxt;
    endtask

    // Advances one clock edge, checks every output against the model, and updates the observation counters.
    task automatic cyc();
        logic e_mmcm, e_idly, e_phy, e_usr, e_done, e_err;
        logic [2:0] e_state;
        @(posedge clk_in);
        model_edge();
        #1;
        cyc_no++;
        if (m_after_reset) begin
            {e_mmcm, e_idly, e_phy, e_usr, e_done, e_err} = 6'b110000;
            e_state = 3'd0;
        end else begin
            e_mmcm  = (m_state == M_MMCM) || (m_state == M_ERROR);
            e_idly  = (m_state == M_IDLY) || (m_state == M_ERROR);
            e_phy   = m_state inside {M_RELPHY, M_RELUSR, M_RUN};
            e_usr   = m_state inside {M_RELUSR, M_RUN};
            e_done  = (m_state == M_RUN);
            e_err   = (m_state == M_ERROR);
            e_state = (m_state == M_ERROR) ? 3'd0 : 3'(m_state);
        end
        check("mmcm_reset", mmcm_reset, e_mmcm);
        check("idelayctrl_rst", idelayctrl_rst, e_idly);
        check("phy_resetn", phy_resetn, e_phy);
        check("usr_resetn", usr_resetn, e_usr);
        check("seq_done", seq_done, e_done);
        check("seq_error", seq_error, e_err);
        check("state_o", state_o, e_state);
        check("retry_cnt", retry_cnt, 3'(m_retry));
        if (mmcm_reset === 1'b1) n_mmcm_hi++;
        if (idelayctrl_rst === 1'b1) n_idly_hi++;
        if (state_o === 3'd2 && seq_error === 1'b0) n_wait_lock++;
        if (phy_resetn === 1'b1 && prev_phy === 1'b0) phy_rise_cyc = cyc_no;
        if (usr_resetn === 1'b1 && prev_usr === 1'b0) usr_rise_cyc = cyc_no;
        if (phy_resetn === 1'b0 && prev_phy === 1'b1) phy_fall_cyc = cyc_no;
        if (usr_resetn === 1'b0 && prev_usr === 1'b1) usr_fall_cyc = cyc_no;
        prev_phy = phy_resetn;
        prev_usr = usr_resetn;
    endtask

    task automatic clear_obs();
        n_mmcm_hi = 0; n_idly_hi = 0; n_wait_lock = 0;
        phy_rise_cyc = -1; usr_rise_cyc = -1; phy_fall_cyc = -1; usr_fall_cyc = -1;
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n = 0;
        while (m_state != target && n < budget) begin
            cyc();
            n++;
        end
        check(tag, {seq_error, state_o}, enc(target));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        restart = 1'b0;
        repeat (n) cyc();
        reset = 1'b0;
        clear_obs();
    endtask

    initial begin
        int rst_left = 0;

        // Nominal bring-up: lock 10 cycles into WAIT_LOCK, ready 5 cycles into WAIT_RDY.
        mmcm_locked = 1'b0; idelayctrl_rdy = 1'b0;
        do_reset(3);
        run_until("A_reach_wait_lock", M_WLOCK, 20);
        repeat (9) cyc();
        mmcm_locked = 1'b1;
        run_until("A_reach_wait_rdy", M_WRDY, 60);
        repeat (4) cyc();
        idelayctrl_rdy = 1'b1;
        run_until("A_reach_run", M_RUN, 60);
        repeat (3) cyc();
        check("A_mmcm_hi_cycles", n_mmcm_hi, 4);
        check("A_idly_hi_cycles", n_idly_hi, 4);
        check("A_phy_to_usr_gap", usr_rise_cyc - phy_rise_cyc, 2);
        check("A_seq_done", seq_done, 1'b1);
        check("A_retry_cnt", retry_cnt, 3'd0);

        // Lock never arrives: two full WAIT_LOCK windows, then ERROR.
        mmcm_locked = 1'b0; idelayctrl_rdy = 1'b0;
        do_reset(2);
        run_until("B_reach_error", M_ERROR, 200);
        repeat (5) cyc();
        check("B_wait_lock_cycles", n_wait_lock, 2 * LOCK_TIMEOUT);
        check("B_seq_error", seq_error, 1'b1);
        check("B_retry_cnt", retry_cnt, 3'd2);
        check("B_mmcm_reset", mmcm_reset, 1'b1);

        // Restart from ERROR, then a randomized successful bring-up.
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("C_state_idle", {seq_error, state_o}, 4'd0);
        check("C_retry_cleared", retry_cnt, 3'd0);
        repeat ($urandom_range(5, 20)) cyc();
        mmcm_locked = 1'b1;
        run_until("C_reach_wait_rdy", M_WRDY, 80);
        repeat ($urandom_range(0, 20)) cyc();
        idelayctrl_rdy = 1'b1;
        run_until("C_reach_run", M_RUN, 80);
        check("C_seq_done", seq_done, 1'b1);

        // Lock drops while in RUN: both resets fall together, then the sequence runs again after lock returns.
        clear_obs();
        mmcm_locked = 1'b0;
        repeat ($urandom_range(1, 4)) cyc();
        mmcm_locked = 1'b1;
        run_until("D_reach_mmcm_rst", M_MMCM, 20);
        run_until("D_reach_run", M_RUN, 200);
        check("D_phy_fell", phy_fall_cyc != -1, 1);
        check("D_fall_same_cycle", usr_fall_cyc, phy_fall_cyc);
        check("D_retry_cnt", retry_cnt, 3'd1);
        check("D_seq_done", seq_done, 1'b1);

        // Ready rises on the second-to-last cycle of WAIT_RDY. The synchronizer delay still causes a timeout.
        mmcm_locked = 1'b1; idelayctrl_rdy = 1'b0;
        do_reset(2);
        run_until("E_reach_wait_rdy", M_WRDY, 60);
        repeat (LOCK_TIMEOUT - 2) cyc();
        idelayctrl_rdy = 1'b1;
        cyc();
        cyc();
        check("E_timeout_to_mmcm_rst", {seq_error, state_o}, 4'd1);
        check("E_retry_cnt", retry_cnt, 3'd1);
        run_until("E_reach_run", M_RUN, 200);
        check("E_retry_kept_in_run", retry_cnt, 3'd1);

        // Reset in the middle of REL_USR, asserted together with restart to show that reset has priority.
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        run_until("F_reach_rel_usr", M_RELUSR, 100);
        cyc();
        reset = 1'b1; restart = 1'b1;
        cyc();
        check("F_mmcm_reset", mmcm_reset, 1'b1);
        check("F_idelayctrl_rst", idelayctrl_rst, 1'b1);
        check("F_resetn_both", {phy_resetn, usr_resetn}, 2'b00);
        check("F_done_error", {seq_done, seq_error}, 2'b00);
        check("F_state_retry", {state_o, retry_cnt}, 6'd0);
        reset = 1'b0; restart = 1'b0;

        // Random soak: lock and ready toggle randomly, with occasional restarts and resets.
        for (int i = 0; i < 2500; i++) begin
            if (mmcm_locked) mmcm_locked = ($urandom_range(0, 149) != 0);
            else             mmcm_locked = ($urandom_range(0, 14) == 0);
            if (idelayctrl_rdy) idelayctrl_rdy = ($urandom_range(0, 99) != 0);
            else                idelayctrl_rdy = ($urandom_range(0, 9) == 0);
            restart = ($urandom_range(0, 299) == 0);
            if (rst_left == 0 && $urandom_range(0, 999) == 0) rst_left = $urandom_range(1, 3);
            reset = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            cyc();
        end
        reset = 1'b0; restart = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
